spi_frame_rx: RTL
=================

# spi_frame_rx

Parametrised SPI slave receive engine for the TRNG/peripheral SPI links. It samples a serial frame on `mosi` under `ss_n` framing in any of the four SPI modes and delivers the assembled word through a valid/ready holding register. It also flags short frames and overruns. All SPI pins are oversampled in the `clk` domain; `sclk` is never used as a clock.

## Interface
- `DATA_WIDTH`, 96: bits per frame; legal range 2..1024.
- `SYNC_STAGES`, 2: synchroniser depth on `sclk`, `mosi` and `ss_n`; legal range 2..4.
- `MSB_FIRST`, 0: 0 = first received bit lands in `data_o[0]`; 1 = first received bit lands in `data_o[DATA_WIDTH-1]`.

- `clk` in 1: system clock. Must run at least 4x `sclk` frequency.
- `rst_n` in 1: asynchronous, active-low reset.
- `cpol` in 1: SPI clock polarity. Latched at frame start.
- `cpha` in 1: SPI clock phase. Latched at frame start.
- `sclk` in 1: SPI clock, asynchronous to `clk`.
- `mosi` in 1: SPI serial data, asynchronous to `clk`.
- `ss_n` in 1: SPI select, active-low, asynchronous to `clk`.
- `data_o` out DATA_WIDTH: received word, held in the holding register.
- `valid_o` out 1: `data_o` holds an unconsumed word.
- `ready_i` in 1: consumer accepts the word on any cycle where `valid_o & ready_i`.
- `busy_o` out 1: a frame is in progress (state ≠ IDLE).
- `frame_err_o` out 1: one-cycle pulse when `ss_n` rises before `DATA_WIDTH` bits have been sampled.
- `overrun_o` out 1: one-cycle pulse when a completed frame overwrites an unconsumed word.

## Operation
- Synchronisers reset to: `sclk` = 0, `mosi` = 0, `ss_n` = 1.
- An edge detector compares the synchronised `sclk` with a one-cycle-delayed copy.
- Leading edge: rising if the latched `cpol` = 0, falling if it is 1.
- Sample edge: leading edge if the latched `cpha` = 0, trailing edge if it is 1. The non-sample edge is ignored.
- Bit counter width is `$clog2(DATA_WIDTH+1)`; the shift register is `DATA_WIDTH` bits wide.
- LSB-first shifting: `{mosi, sr[DATA_WIDTH-1:1]}`. MSB-first shifting: `{sr[DATA_WIDTH-2:0], mosi}`.
- State machine (4 states):
  - IDLE: on the synchronised `ss_n` falling edge, latch `cpol`/`cpha`, clear the counter and shift register, go to RECV.
  - RECV: each sample edge shifts in one bit and increments the counter. The sample edge that brings the count to `DATA_WIDTH` goes to LOAD. If `ss_n` rises first: pulse `frame_err_o`, discard the partial word, go to IDLE.
  - LOAD: one cycle. `data_o <= sr`, `valid_o <= 1`. If `valid_o & ~ready_i` in this cycle, pulse `overrun_o`; the new word replaces the old one. Go to WAIT_SS.
  - WAIT_SS: all `sclk` edges are ignored. Go to IDLE when the synchronised `ss_n` = 1. If `ss_n` is already high in LOAD, pass through WAIT_SS for one cycle.
- Holding register behaviour:
  - `valid_o` clears on `valid_o & ready_i`, unless LOAD occurs in the same cycle.
  - LOAD together with `ready_i` while `valid_o` is set: the old word is consumed, the new word is loaded, `valid_o` stays 1, no overrun.
- `data_o` holds its value when `valid_o` = 0; it is never zeroed after reset.
- Changes to `cpol`/`cpha` mid-frame have no effect.

## Timing
- Reset values: `data_o` = 0, `valid_o` = 0, `busy_o` = 0, `frame_err_o` = 0, `overrun_o` = 0; state = IDLE.
- Pin-to-detect latency: a pin transition is seen by the edge detector `SYNC_STAGES` cycles later. The shift and count happen at the end of that detect cycle.
- Frame completion: state enters LOAD on the cycle after the last sample edge is detected. `valid_o` and the new `data_o` are visible on the following cycle, i.e. 2 clk after the detect cycle.
- `frame_err_o` is asserted in the cycle after the `ss_n` rise is detected in RECV.
- `busy_o` rises in the cycle after the `ss_n` fall is detected and falls on the return to IDLE.
- Reset mid-frame: all state and outputs return to their reset values immediately (asynchronous). Bits already shifted are lost.
- An `ss_n` fall in WAIT_SS is not a new frame; `ss_n` must first be seen high in IDLE-bound WAIT_SS.

## Test plan
- **Mode 0, DATA_WIDTH=96, LSB first:** send 96'h0123_4567_89AB_CDEF_FEDC_BA98, then `ready_i`=1 -> `valid_o` for 1 cycle, `data_o` = 96'h0123_4567_89AB_CDEF_FEDC_BA98, no error pulses.
- **All four modes, DATA_WIDTH=8, MSB_FIRST=1:** send 8'hA5 in each mode, `sclk` = `clk`/8 -> `data_o` = 8'hA5 every time. With `cpha` mismatched to the transmitter, the result differs.
- **Short frame:** raise `ss_n` after 50 of 96 bits -> `frame_err_o` pulses once, `valid_o` stays 0, the next full frame is received correctly.
- **Overrun:** hold `ready_i`=0 and send 8'h11 then 8'h22 -> `overrun_o` pulses once at the second LOAD, `data_o` = 8'h22, `valid_o` = 1.
- **Simultaneous:** assert `ready_i` in the exact LOAD cycle of a second frame -> no overrun, `valid_o` stays 1, `data_o` = new word.
- **Reset mid-frame:** assert `rst_n`=0 after 30 bits, then release -> all outputs 0, state IDLE, a subsequent frame of 8'h3C is received intact. Also send 4 extra `sclk` edges after bit `DATA_WIDTH`, before `ss_n` rises -> ignored, word unchanged.

Source files
------------

// File: rtl/spi_frame_rx.sv
// rtl/spi_frame_rx.sv - oversampled SPI slave receiver with valid/ready holding register
// All SPI pins are synchronised into clk; sclk edges are detected, never used as a clock.
module spi_frame_rx #(
  parameter int DATA_WIDTH  = 96,
  parameter int SYNC_STAGES = 2,
  parameter bit MSB_FIRST   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpol,
  input  logic                  cpha,
  input  logic                  sclk,
  input  logic                  mosi,
  input  logic                  ss_n,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  busy_o,
  output logic                  frame_err_o,
  output logic                  overrun_o
);

  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RECV,
    S_LOAD,
    S_WAIT_SS
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_ss_sync;
  logic                   r_sclk_d;
  logic                   r_ss_d;

  logic                   r_cpol;
  logic                   r_cpha;
  logic [CW-1:0]          r_cnt;
  logic [DATA_WIDTH-1:0]  r_sr;
  logic [DATA_WIDTH-1:0]  r_data;
  logic                   r_valid;
  logic                   r_frame_err;
  logic                   r_overrun;

  logic w_sclk, w_mosi, w_ss;
  logic w_sclk_rise, w_sclk_fall, w_ss_rise, w_ss_fall;
  logic w_lead, w_trail, w_sample;
  logic w_start, w_shift, w_abort, w_load;

  // Idle levels: sclk low, mosi low, ss_n deasserted
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sclk_sync <= '0;
      r_mosi_sync <= '0;
      r_ss_sync   <= '1;
      r_sclk_d    <= 1'b0;
      r_ss_d      <= 1'b1;
    end else begin
      r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], sclk};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
      r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], ss_n};
      r_sclk_d    <= w_sclk;
      r_ss_d      <= w_ss;
    end
  end

  assign w_sclk      = r_sclk_sync[SYNC_STAGES-1];
  assign w_mosi      = r_mosi_sync[SYNC_STAGES-1];
  assign w_ss        = r_ss_sync[SYNC_STAGES-1];
  assign w_sclk_rise = w_sclk & ~r_sclk_d;
  assign w_sclk_fall = ~w_sclk & r_sclk_d;
  assign w_ss_rise   = w_ss & ~r_ss_d;
  assign w_ss_fall   = ~w_ss & r_ss_d;
  assign w_lead      = r_cpol ? w_sclk_fall : w_sclk_rise;
  assign w_trail     = r_cpol ? w_sclk_rise : w_sclk_fall;
  assign w_sample    = r_cpha ? w_trail : w_lead;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next  = r_state;
    w_start = 1'b0;
    w_shift = 1'b0;
    w_abort = 1'b0;
    w_load  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_ss_fall) begin
          w_start = 1'b1;
          w_next  = S_RECV;
        end
      end
      S_RECV: begin
        if (w_ss_rise) begin
          w_abort = 1'b1;
          w_next  = S_IDLE;
        end else if (w_sample) begin
          w_shift = 1'b1;
          if (r_cnt == LAST_CNT) begin
            w_next = S_LOAD;
          end
        end
      end
      S_LOAD: begin
        w_load = 1'b1;
        w_next = S_WAIT_SS;
      end
      S_WAIT_SS: begin
        if (w_ss) begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cpol      <= 1'b0;
      r_cpha      <= 1'b0;
      r_cnt       <= '0;
      r_sr        <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_abort;
      r_overrun   <= w_load & r_valid & ~ready_i;

      if (w_start) begin
        r_cpol <= cpol;
        r_cpha <= cpha;
        r_cnt  <= '0;
        r_sr   <= '0;
      end else if (w_shift) begin
        r_cnt <= r_cnt + CW'(1);
        if (MSB_FIRST) begin
          r_sr <= {r_sr[DATA_WIDTH-2:0], w_mosi};
        end else begin
          r_sr <= {w_mosi, r_sr[DATA_WIDTH-1:1]};
        end
      end

      // A load wins over a same-cycle consume, so valid stays set
      if (w_load) begin
        r_data  <= r_sr;
        r_valid <= 1'b1;
      end else if (r_valid && ready_i) begin
        r_valid <= 1'b0;
      end
    end
  end

  assign data_o      = r_data;
  assign valid_o     = r_valid;
  assign busy_o      = (r_state != S_IDLE);
  assign frame_err_o = r_frame_err;
  assign overrun_o   = r_overrun;

endmodule
